vec_cache_edge_rdata_collector: RTL and testbench

- Sits at the west edge of each XY-switch row and consumes the 8-channel west data outputs of the edge switch.
- Absorbs the un-throttled per-channel return data into per-channel FIFOs.
- Merges the 8 channels onto one valid/ready stream toward the requester using a round-robin arbiter.
- Returns per-channel credits so the upstream read-issue logic never overruns a FIFO.

---
 rtl/vector_cache_pkg.sv | 20 ++
 rtl/vec_cache_rr_arb8.sv | 39 +++
 rtl/vec_cache_sync_fifo.sv | 49 ++++
 rtl/vec_cache_edge_rdata_collector.sv | 119 +++++++++++
 tb/tb_vec_cache_edge_rdata_collector.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and constants: payload struct, channel count,
// collector FIFO depth and the switch port direction codes.
`ifndef VEC_CACHE_WEST
`define VEC_CACHE_WEST  2'd0
`define VEC_CACHE_EAST  2'd1
`define VEC_CACHE_NORTH 2'd2
`define VEC_CACHE_SOUTH 2'd3
`endif

package vector_cache_pkg;

   localparam int VEC_CACHE_CHN_NUM            = 8;
   localparam int VEC_CACHE_COLLECT_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [5:0]  req_id;
      logic [31:0] data;
   } data_pld_t;

endpackage

// File: rtl/vec_cache_rr_arb8.sv
// 8-way round-robin arbiter. Search starts at the pointer, or at acc_idx+1
// when a grant is being accepted this cycle, so back-to-back grants rotate.
module vec_cache_rr_arb8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       lock,
   input  logic       acc,
   input  logic [2:0] acc_idx,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld
);
   logic [2:0] ptr_q;
   logic [2:0] base;

   assign base = acc ? acc_idx + 3'd1 : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= base;
   end

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      if (!lock) begin
         for (int k = 0; k < 8; k++) begin
            if (!gnt_vld && req[base + 3'(k)]) begin
               gnt_vld = 1'b1;
               gnt_idx = base + 3'(k);
            end
         end
      end
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/vec_cache_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; also exposes the entry
// behind the head so a consumer can pop and re-read in the same cycle.
module vec_cache_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [W-1:0] rdata_nxt,
   output logic         full,
   output logic         empty,
   output logic         multi
);
   localparam int          AW  = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   cnt;
   logic [AW-1:0] rd_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE;
         if (pop)  rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign cnt       = wr_ptr - rd_ptr;
   assign rd_nxt    = rd_ptr[AW-1:0] + ONE[AW-1:0];
   assign rdata     = mem[rd_ptr[AW-1:0]];
   assign rdata_nxt = mem[rd_nxt];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign multi     = (cnt > ONE);

endmodule

// File: rtl/vec_cache_edge_rdata_collector.sv
// West-edge return-data collector: per-channel FIFOs merged round-robin onto one
// registered stream, with credit return. VEC_CACHE_COLLECT_BYPASS_EN enables the FIFO bypass.
module vec_cache_edge_rdata_collector
   import vector_cache_pkg::*;
#(
   parameter int CHN_NUM    = VEC_CACHE_CHN_NUM,
   parameter int FIFO_DEPTH = VEC_CACHE_COLLECT_FIFO_DEPTH,
   parameter int ROW_ID     = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHN_NUM-1:0]       in_vld,
   input  data_pld_t [CHN_NUM-1:0]  in_pld,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output data_pld_t                out_pld,
   output logic [2:0]               out_ch,
   output logic [1:0]               out_row_id,
   output logic [CHN_NUM-1:0]       crd_rtn,
   output logic [CHN_NUM-1:0]       ovf_err,
   output logic [CHN_NUM-1:0]       fifo_empty
);
   logic [CHN_NUM-1:0]      full, empty, multi, pop, push, req, gnt;
   data_pld_t [CHN_NUM-1:0] rdata, rdata_nxt, cand;
   data_pld_t               sel_pld;
   logic [2:0]              gnt_idx, byp_idx;
   logic                    gnt_vld, hs, load, byp_take, out_byp;

   assign hs         = out_vld && out_rdy;
   assign load       = !out_vld || out_rdy;
   assign out_row_id = ROW_ID[1:0];
   assign fifo_empty = empty;
   assign push       = in_vld & (~full | pop) & ~{CHN_NUM{byp_take}};

   // The output register mirrors the FIFO head; the entry is only popped on
   // acceptance, so a popping channel competes with its second entry.
   for (genvar i = 0; i < CHN_NUM; i++) begin : g_ch
      vec_cache_sync_fifo #(.W($bits(data_pld_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (push[i]),
         .pop       (pop[i]),
         .wdata     (in_pld[i]),
         .rdata     (rdata[i]),
         .rdata_nxt (rdata_nxt[i]),
         .full      (full[i]),
         .empty     (empty[i]),
         .multi     (multi[i])
      );
      assign pop[i]  = hs && !out_byp && (out_ch == 3'(i));
      assign req[i]  = pop[i] ? multi[i] : !empty[i];
      assign cand[i] = pop[i] ? rdata_nxt[i] : rdata[i];
   end

   vec_cache_rr_arb8 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .lock    (!load),
      .acc     (hs),
      .acc_idx (out_ch),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      sel_pld = '0;
      for (int i = 0; i < CHN_NUM; i++) begin
         if (gnt[i]) sel_pld = cand[i];
      end
   end

`ifdef VEC_CACHE_COLLECT_BYPASS_EN
   always_comb begin
      byp_idx = '0;
      for (int i = 0; i < CHN_NUM; i++) begin
         if (in_vld[i]) byp_idx = 3'(i);
      end
   end

   assign byp_take = load && (&empty) && $onehot(in_vld);

   // Bypassed beats have no FIFO entry behind them, so acceptance must not pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    out_byp <= 1'b0;
      else if (load) out_byp <= byp_take;
   end
`else
   assign byp_idx  = '0;
   assign byp_take = 1'b0;
   assign out_byp  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_pld <= '0;
         out_ch  <= '0;
         crd_rtn <= '0;
         ovf_err <= '0;
      end else begin
         crd_rtn <= hs ? (CHN_NUM'(1) << out_ch) : '0;
         ovf_err <= ovf_err | (in_vld & full & ~pop);
         if (byp_take) begin
            out_vld <= 1'b1;
            out_pld <= in_pld[byp_idx];
            out_ch  <= byp_idx;
         end else if (load) begin
            out_vld <= gnt_vld;
            if (gnt_vld) begin
               out_pld <= sel_pld;
               out_ch  <= gnt_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_cache_edge_rdata_collector.sv
// Bench for the edge read-data collector: directed scenarios plus random traffic,
// all checked every cycle against a queue-level model of the merge rules.
module tb_vec_cache_edge_rdata_collector;
   import vector_cache_pkg::*;

   localparam int DEPTH = 4;

   logic            clk;
   logic            rst_n;
   logic [7:0]      in_vld;
   data_pld_t [7:0] in_pld;
   logic            out_vld;
   logic            out_rdy;
   data_pld_t       out_pld;
   logic [2:0]      out_ch;
   logic [1:0]      out_row_id;
   logic [7:0]      crd_rtn;
   logic [7:0]      ovf_err;
   logic [7:0]      fifo_empty;

   int checks   = 0;
   int failures = 0;
   int crd_cnt [8];

   data_pld_t  mq [8][$];
   logic       m_vld;
   data_pld_t  m_pld;
   logic [2:0] m_ch;
   logic [2:0] m_ptr;
   logic [7:0] m_crd;
   logic [7:0] m_ovf;

   vec_cache_edge_rdata_collector #(.CHN_NUM(8), .FIFO_DEPTH(DEPTH), .ROW_ID(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_vld     (in_vld),
      .in_pld     (in_pld),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_pld    (out_pld),
      .out_ch     (out_ch),
      .out_row_id (out_row_id),
      .crd_rtn    (crd_rtn),
      .ovf_err    (ovf_err),
      .fifo_empty (fifo_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mq[i].delete();
      m_vld = 1'b0; m_pld = '0; m_ch = '0; m_ptr = '0; m_crd = '0; m_ovf = '0;
   endtask

   // One clock edge of the collector, stated as queue operations:
   // accept/pop, choose next head round-robin from post-pop queues, then push.
   task automatic model_edge();
      logic      hs;
      logic      found;
      int        win;
      data_pld_t dummy;
      hs    = m_vld && out_rdy;
      m_crd = hs ? (8'h01 << m_ch) : 8'h00;
      if (hs) begin
         dummy = mq[m_ch].pop_front();
         m_ptr = m_ch + 3'd1;
      end
      if (hs || !m_vld) begin
         found = 1'b0;
         win   = 0;
         for (int k = 0; k < 8; k++) begin
            int c;
            c = (int'(m_ptr) + k) % 8;
            if (!found && mq[c].size() > 0) begin
               found = 1'b1;
               win   = c;
            end
         end
         m_vld = found;
         if (found) begin
            m_ch  = 3'(win);
            m_pld = mq[win][0];
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (in_vld[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(in_pld[i]);
            else m_ovf[i] = 1'b1;
         end
      end
   endtask

   task automatic compare();
      logic [7:0] exp_empty;
      for (int i = 0; i < 8; i++) exp_empty[i] = (mq[i].size() == 0);
      chk("out_vld", 64'(out_vld), 64'(m_vld));
      if (m_vld) begin
         chk("out_pld", 64'(out_pld), 64'(m_pld));
         chk("out_ch", 64'(out_ch), 64'(m_ch));
      end
      chk("crd_rtn", 64'(crd_rtn), 64'(m_crd));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      chk("fifo_empty", 64'(fifo_empty), 64'(exp_empty));
   endtask

   task automatic step(input logic [7:0] vld, input logic rdy);
      in_vld  = vld;
      out_rdy = rdy;
      for (int i = 0; i < 8; i++) begin
         in_pld[i].req_id = 6'($urandom);
         in_pld[i].data   = $urandom;
      end
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 8; i++) if (crd_rtn[i]) crd_cnt[i]++;
      compare();
      in_vld = '0;
   endtask

   task automatic clr_crd();
      for (int i = 0; i < 8; i++) crd_cnt[i] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_out_pld", 64'(out_pld), 64'd0);
      chk("rst_out_ch", 64'(out_ch), 64'd0);
      chk("rst_crd_rtn", 64'(crd_rtn), 64'd0);
      chk("rst_ovf_err", 64'(ovf_err), 64'd0);
      chk("rst_fifo_empty", 64'(fifo_empty), 64'hFF);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b1;
      in_vld  = '0;
      in_pld  = '0;
      out_rdy = 1'b0;
      clr_crd();
      model_reset();
      #2;
      do_reset();
      chk("row_id", 64'(out_row_id), 64'd0);

      // single beat on channel 2
      clr_crd();
      step(8'h04, 1'b1);
      chk("single_lat0", 64'(out_vld), 64'd0);
      step(8'h00, 1'b1);
      chk("single_vld", 64'(out_vld), 64'd1);
      chk("single_ch", 64'(out_ch), 64'd2);
      step(8'h00, 1'b1);
      chk("single_crd", 64'(crd_rtn), 64'h04);
      step(8'h00, 1'b1);
      chk("single_crd_off", 64'(crd_rtn), 64'h00);

      // all channels at once drain in order 0..7
      do_reset();
      clr_crd();
      step(8'hFF, 1'b1);
      for (int n = 0; n < 8; n++) begin
         step(8'h00, 1'b1);
         chk("rr_ch", 64'(out_ch), 64'(n));
      end
      repeat (3) step(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) chk("rr_crd_cnt", 64'(crd_cnt[i]), 64'd1);

      // backpressure on channel 5
      do_reset();
      clr_crd();
      step(8'h20, 1'b0);
      repeat (10) step(8'h00, 1'b0);
      chk("bp_ch", 64'(out_ch), 64'd5);
      chk("bp_crd_cnt", 64'(crd_cnt[5]), 64'd0);
      repeat (3) step(8'h00, 1'b1);
      chk("bp_crd_after", 64'(crd_cnt[5]), 64'd1);

      // overflow on channel 3
      do_reset();
      clr_crd();
      repeat (5) step(8'h08, 1'b0);
      chk("ovf_set", 64'(ovf_err), 64'h08);
      repeat (8) step(8'h00, 1'b1);
      chk("ovf_crd_cnt", 64'(crd_cnt[3]), 64'd4);
      chk("ovf_sticky", 64'(ovf_err), 64'h08);

      // full FIFO with simultaneous push and pop on channel 1
      do_reset();
      clr_crd();
      repeat (4) step(8'h02, 1'b0);
      step(8'h02, 1'b1);
      chk("fpp_ovf", 64'(ovf_err), 64'h00);
      chk("fpp_occ", 64'(mq[1].size()), 64'd4);
      repeat (7) step(8'h00, 1'b1);
      chk("fpp_crd_cnt", 64'(crd_cnt[1]), 64'd5);

      // random traffic
      do_reset();
      for (int n = 0; n < 400; n++) begin
         step(8'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0));
      end
      repeat (40) step(8'h00, 1'b1);

      // reset with three channels holding data
      do_reset();
      step(8'h45, 1'b0);
      step(8'h45, 1'b0);
      chk("mid_nonempty", 64'(fifo_empty), 64'hBA);
      do_reset();
      clr_crd();
      repeat (10) step(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) chk("mid_no_crd", 64'(crd_cnt[i]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
